blast_array: RTL and testbench
==============================

# blast_array

Multi-channel successor to the single-blast controller. It tracks up to NUM_BLASTS simultaneous explosions, each with its own centre, radius and lifetime. On each `blast` request it allocates a free channel, latches that channel's blast-bitmap top-left corner (offset by the latched radius) and holds it for DURATION_SEC one-second pulses. Sits between the bomb controllers and the blast drawing/collision logic.

## Interface
Parameters:
- NUM_BLASTS, 4, number of independent blast channels (1..8)
- TILE, 32, tile size in pixels; offset per radius step
- MAX_RADIUS, 3, largest legal radius in tiles; RW = $clog2(MAX_RADIUS+1)
- DURATION_SEC, 1, blast lifetime in OneSecPulse ticks (1..15)
- OFF_X, 640 / OFF_Y, 480, parked (off-screen) coordinates for idle channels

Ports:
- clk  in  1  system clock
- resetN  in  1  reset; synchronous, active-low
- OneSecPulse  in  1  single-cycle tick, once per second
- clear  in  1  synchronous flush of all channels (level change / game over)
- blast  in  1  single-cycle blast request
- blastRadius  in  RW  requested radius in tiles
- bomb_topLeftX  in  11  bomb top-left X, unsigned
- bomb_topLeftY  in  11  bomb top-left Y, unsigned
- topLeftX  out  NUM_BLASTS*11  per-channel signed top-left X; channel i at [11*i+10:11*i]
- topLeftY  out  NUM_BLASTS*11  per-channel signed top-left Y
- radius  out  NUM_BLASTS*RW  per-channel latched radius
- explode  out  NUM_BLASTS  per-channel active flag
- full  out  1  all channels active
- dropped  out  1  one-cycle pulse: request rejected because full

## Operation
- Each channel is an FSM with two states, S_IDLE and S_EXPLODE, plus a 4-bit seconds counter `secs`.
- Channel in S_IDLE: explode=0, topLeftX=OFF_X, topLeftY=OFF_Y, radius=0.
- Allocation: `blast`=1 selects the lowest-index channel in S_IDLE (priority encoder). That channel then:
  - enters S_EXPLODE with explode=1
  - sets secs=DURATION_SEC
  - latches r = clamp(blastRadius), where 0 becomes 1 and values above MAX_RADIUS become MAX_RADIUS
  - sets topLeftX = bomb_topLeftX − r*TILE and topLeftY = bomb_topLeftY − r*TILE
  - sets radius=r
- Only one channel is allocated per request.
- Arithmetic: 11-bit signed two's complement, and the result may go negative (partly off-screen). Example: X=20, r=1, TILE=32 gives −12.
- No free channel: the request is ignored, `dropped`=1 for one cycle, and no channel state changes.
- S_EXPLODE: on OneSecPulse, secs decrements. If secs==1 at that pulse, the channel returns to S_IDLE with outputs parked.
- Lifetime is therefore DURATION_SEC full or partial seconds: the first pulse after allocation counts.
- `full` = AND of explode, registered from the same state as explode.
- clear=1: all channels go to S_IDLE next cycle. clear has priority over blast and OneSecPulse, and any blast in that cycle is dropped silently (dropped stays 0).

## Timing
- Reset (resetN=0 at a clk edge) puts every channel in S_IDLE with explode=0, topLeftX=OFF_X, topLeftY=OFF_Y, radius=0, secs=0, full=0, dropped=0. Reset mid-blast aborts the blast immediately.
- Latency: blast at edge N gives explode/coords valid after edge N (visible in cycle N+1). Expiry pulse at edge M gives parked outputs after edge M.
- blast and OneSecPulse in the same cycle:
  - the newly allocated channel ignores that pulse, keeping secs=DURATION_SEC
  - other active channels decrement normally
- A channel expiring in the same cycle as a blast is not reusable in that cycle; allocation sees the pre-edge state.
- Back-to-back blast requests on consecutive cycles allocate consecutive free channels.
- bomb_topLeftX/Y and blastRadius are sampled only on the allocating edge; later changes do not affect active channels.
- startOfFrame is not used. Outputs are registered and stable for the whole frame between edges that change them.

## Test plan
- Reset → all explode=0, coords 640/480, full=0. Then blast with X=200, Y=160, r=2, TILE=32 → channel 0 explode=1 at (136, 96), radius=2 one cycle later.
- Edge radius values: request with r=0 → radius=1 at (X−32, Y−32). Request with r=7, MAX_RADIUS=3 → radius=3 at (X−96, Y−96). X=10, r=1 → topLeftX=−22 (11'h7EA).
- Fill and overflow (NUM_BLASTS=4): five blasts on consecutive cycles → channels 0..3 active, full=1, and the fifth gives dropped=1 for exactly one cycle. Then one pulse with DURATION_SEC=1 → all idle, full=0.
- Lifetime (DURATION_SEC=3): blast then three OneSecPulses → explode stays 1 through the second pulse and clears after the third. A blast in the same cycle as a pulse survives exactly 3 further pulses.
- Reuse: channel 1 expires while 0 and 2 remain active → the next blast takes channel 1.
- clear or resetN asserted mid-explosion alongside a blast → all channels idle next cycle, and the request is not allocated and not flagged as dropped.

Source files
------------

// File: rtl/blast_array.sv
// blast_array: tracks up to NUM_BLASTS concurrent explosions, each with its
// own latched corner, radius and seconds countdown.
module blast_array #(
    parameter int NUM_BLASTS   = 4,
    parameter int TILE         = 32,
    parameter int MAX_RADIUS   = 3,
    parameter int DURATION_SEC = 1,
    parameter int OFF_X        = 640,
    parameter int OFF_Y        = 480,
    localparam int RW          = $clog2(MAX_RADIUS + 1)
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       OneSecPulse,
    input  logic                       clear,
    input  logic                       blast,
    input  logic [RW-1:0]              blastRadius,
    input  logic [10:0]                bomb_topLeftX,
    input  logic [10:0]                bomb_topLeftY,
    output logic [NUM_BLASTS*11-1:0]   topLeftX,
    output logic [NUM_BLASTS*11-1:0]   topLeftY,
    output logic [NUM_BLASTS*RW-1:0]   radius,
    output logic [NUM_BLASTS-1:0]      explode,
    output logic                       full,
    output logic                       dropped
);

    typedef enum logic {
        S_IDLE,
        S_EXPLODE
    } state_t;

    state_t                          state_q [NUM_BLASTS];
    state_t                          state_d [NUM_BLASTS];
    logic [NUM_BLASTS-1:0][3:0]      secs_q, secs_d;
    logic [NUM_BLASTS-1:0][10:0]     x_q, x_d;
    logic [NUM_BLASTS-1:0][10:0]     y_q, y_d;
    logic [NUM_BLASTS-1:0][RW-1:0]   r_q, r_d;
    logic [NUM_BLASTS-1:0]           explode_q, explode_d;
    logic                            full_q, full_d;
    logic                            dropped_q, dropped_d;

    logic [NUM_BLASTS-1:0]           grant;
    logic                            found;
    logic [RW-1:0]                   r_clamp;
    logic [10:0]                     offset;

    always_comb begin
        if (blastRadius == '0) begin
            r_clamp = RW'(1);
        end else if (int'(blastRadius) > MAX_RADIUS) begin
            r_clamp = RW'(MAX_RADIUS);
        end else begin
            r_clamp = blastRadius;
        end
        offset = 11'(int'(r_clamp) * TILE);
    end

    // Priority encoder over the pre-edge state: lowest idle channel wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_BLASTS; i++) begin
            if (state_q[i] == S_IDLE && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        dropped_d = 1'b0;
        for (int i = 0; i < NUM_BLASTS; i++) begin
            state_d[i] = state_q[i];
            secs_d[i]  = secs_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            r_d[i]     = r_q[i];
        end

        if (clear) begin
            for (int i = 0; i < NUM_BLASTS; i++) begin
                state_d[i] = S_IDLE;
                secs_d[i]  = '0;
                x_d[i]     = 11'(OFF_X);
                y_d[i]     = 11'(OFF_Y);
                r_d[i]     = '0;
            end
        end else begin
            for (int i = 0; i < NUM_BLASTS; i++) begin
                if (state_q[i] == S_EXPLODE && OneSecPulse) begin
                    if (secs_q[i] == 4'd1) begin
                        state_d[i] = S_IDLE;
                        secs_d[i]  = '0;
                        x_d[i]     = 11'(OFF_X);
                        y_d[i]     = 11'(OFF_Y);
                        r_d[i]     = '0;
                    end else begin
                        secs_d[i] = secs_q[i] - 4'd1;
                    end
                end
                // A freshly allocated channel was idle, so it never sees the pulse.
                if (blast && grant[i]) begin
                    state_d[i] = S_EXPLODE;
                    secs_d[i]  = 4'(DURATION_SEC);
                    x_d[i]     = bomb_topLeftX - offset;
                    y_d[i]     = bomb_topLeftY - offset;
                    r_d[i]     = r_clamp;
                end
            end
            dropped_d = blast && !found;
        end

        full_d = 1'b1;
        for (int i = 0; i < NUM_BLASTS; i++) begin
            explode_d[i] = (state_d[i] == S_EXPLODE);
            full_d       = full_d & explode_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_BLASTS; i++) begin
                state_q[i] <= S_IDLE;
                secs_q[i]  <= '0;
                x_q[i]     <= 11'(OFF_X);
                y_q[i]     <= 11'(OFF_Y);
                r_q[i]     <= '0;
            end
            explode_q <= '0;
            full_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BLASTS; i++) begin
                state_q[i] <= state_d[i];
                secs_q[i]  <= secs_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                r_q[i]     <= r_d[i];
            end
            explode_q <= explode_d;
            full_q    <= full_d;
            dropped_q <= dropped_d;
        end
    end

    assign topLeftX = x_q;
    assign topLeftY = y_q;
    assign radius   = r_q;
    assign explode  = explode_q;
    assign full     = full_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_blast_array.sv
// tb_blast_array: directed and random stimulus against a per-channel
// reference model of the blast allocator.
module tb_blast_array;

    localparam int NB   = 4;
    localparam int TILE = 32;
    localparam int MAXR = 5;
    localparam int DUR  = 3;
    localparam int RW   = $clog2(MAXR + 1);

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               OneSecPulse = 1'b0;
    logic               clear = 1'b0;
    logic               blast = 1'b0;
    logic [RW-1:0]      blastRadius = '0;
    logic [10:0]        bomb_topLeftX = '0;
    logic [10:0]        bomb_topLeftY = '0;
    logic [NB*11-1:0]   topLeftX;
    logic [NB*11-1:0]   topLeftY;
    logic [NB*RW-1:0]   radius;
    logic [NB-1:0]      explode;
    logic               full;
    logic               dropped;

    int n_vec = 0;
    int n_err = 0;

    bit m_act [NB];
    int m_secs [NB];
    int m_x [NB];
    int m_y [NB];
    int m_r [NB];
    bit m_drop;
    bit m_full;

    blast_array #(
        .NUM_BLASTS(NB),
        .TILE(TILE),
        .MAX_RADIUS(MAXR),
        .DURATION_SEC(DUR),
        .OFF_X(640),
        .OFF_Y(480)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .OneSecPulse(OneSecPulse),
        .clear(clear),
        .blast(blast),
        .blastRadius(blastRadius),
        .bomb_topLeftX(bomb_topLeftX),
        .bomb_topLeftY(bomb_topLeftY),
        .topLeftX(topLeftX),
        .topLeftY(topLeftY),
        .radius(radius),
        .explode(explode),
        .full(full),
        .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic park(input int i);
        m_act[i]  = 1'b0;
        m_secs[i] = 0;
        m_x[i]    = 640;
        m_y[i]    = 480;
        m_r[i]    = 0;
    endtask

    task automatic model_edge();
        int free;
        int r;
        free = -1;
        for (int i = NB - 1; i >= 0; i--)
            if (!m_act[i]) free = i;
        m_drop = 1'b0;
        if (!resetN || clear) begin
            for (int i = 0; i < NB; i++) park(i);
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (m_act[i] && OneSecPulse) begin
                    if (m_secs[i] == 1) park(i);
                    else m_secs[i]--;
                end
            end
            if (blast) begin
                if (free < 0) begin
                    m_drop = 1'b1;
                end else begin
                    r = int'(blastRadius);
                    if (r < 1) r = 1;
                    if (r > MAXR) r = MAXR;
                    m_act[free]  = 1'b1;
                    m_secs[free] = DUR;
                    m_r[free]    = r;
                    m_x[free]    = int'(bomb_topLeftX) - r * TILE;
                    m_y[free]    = int'(bomb_topLeftY) - r * TILE;
                end
            end
        end
        m_full = 1'b1;
        for (int i = 0; i < NB; i++) m_full &= m_act[i];
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NB; i++) begin
            logic [10:0] ex;
            logic [10:0] ey;
            ex = 11'(m_x[i]);
            ey = 11'(m_y[i]);
            check($sformatf("%s explode%0d", tag, i), 32'(explode[i]),
                  32'(m_act[i]));
            check($sformatf("%s x%0d", tag, i), 32'(topLeftX[11*i +: 11]),
                  32'(ex));
            check($sformatf("%s y%0d", tag, i), 32'(topLeftY[11*i +: 11]),
                  32'(ey));
            check($sformatf("%s r%0d", tag, i), 32'(radius[RW*i +: RW]),
                  32'(m_r[i]));
        end
        check({tag, " full"}, 32'(full), 32'(m_full));
        check({tag, " dropped"}, 32'(dropped), 32'(m_drop));
    endtask

    task automatic step(input string tag, input bit rn, input bit b,
                        input bit p, input bit c, input int r,
                        input int x, input int y);
        @(negedge clk);
        resetN        = rn;
        blast         = b;
        OneSecPulse   = p;
        clear         = c;
        blastRadius   = RW'(r);
        bomb_topLeftX = 11'(x);
        bomb_topLeftY = 11'(y);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < NB; i++) park(i);
        m_drop = 1'b0;
        m_full = 1'b0;

        step("reset", 0, 0, 0, 0, 0, 0, 0);
        step("reset2", 0, 1, 1, 0, 2, 100, 100);
        step("idle", 1, 0, 0, 0, 0, 0, 0);

        step("blast200", 1, 1, 0, 0, 2, 200, 160);
        check("ch0 x136", 32'(topLeftX[10:0]), 32'd136);
        check("ch0 y96", 32'(topLeftY[10:0]), 32'd96);
        step("r0", 1, 1, 0, 0, 0, 300, 300);
        check("ch1 r1", 32'(radius[RW +: RW]), 32'd1);
        step("r7", 1, 1, 0, 0, 7, 400, 400);
        check("ch2 rmax", 32'(radius[2*RW +: RW]), 32'(MAXR));
        step("neg", 1, 1, 0, 0, 1, 10, 20);
        check("ch3 x-22", 32'(topLeftX[43:33]), 32'h7EA);
        check("full", 32'(full), 32'd1);
        step("overflow", 1, 1, 0, 0, 1, 50, 50);
        check("dropped", 32'(dropped), 32'd1);
        step("after_ovf", 1, 0, 0, 0, 0, 0, 0);
        check("dropped1cyc", 32'(dropped), 32'd0);

        step("exp_p1", 1, 0, 1, 0, 0, 0, 0);
        step("exp_p2", 1, 0, 1, 0, 0, 0, 0);
        step("exp_p3", 1, 0, 1, 0, 0, 0, 0);
        check("all idle", 32'(explode), 32'd0);

        step("life_b", 1, 1, 0, 0, 2, 500, 300);
        step("life_p1", 1, 0, 1, 0, 0, 0, 0);
        step("life_g", 1, 0, 0, 0, 0, 0, 0);
        step("life_bp", 1, 1, 1, 0, 3, 600, 200);
        step("life_p3", 1, 0, 1, 0, 0, 0, 0);
        check("ch0 gone", 32'(explode[0]), 32'd0);
        step("life_p4", 1, 0, 1, 0, 0, 0, 0);
        step("life_p5", 1, 0, 1, 0, 0, 0, 0);
        check("ch1 gone", 32'(explode[1]), 32'd0);

        step("reuse_b0", 1, 1, 0, 0, 1, 100, 100);
        step("reuse_p", 1, 0, 1, 0, 0, 0, 0);
        step("reuse_b1", 1, 1, 0, 0, 2, 200, 200);
        step("reuse_p2", 1, 0, 1, 0, 0, 0, 0);
        step("reuse_x0", 1, 0, 1, 0, 0, 0, 0);
        step("reuse_b0b", 1, 1, 0, 0, 3, 300, 300);
        step("reuse_b2", 1, 1, 0, 0, 1, 400, 400);
        step("reuse_p3", 1, 0, 1, 0, 0, 0, 0);
        step("reuse_x1", 1, 0, 1, 0, 0, 0, 0);
        check("ch1 idle", 32'(explode), 32'b0101);
        step("reuse_b1b", 1, 1, 0, 0, 2, 700, 100);
        check("ch1 reused", 32'(explode), 32'b0111);

        step("clr_blast", 1, 1, 1, 1, 1, 100, 100);
        check("clr idle", 32'(explode), 32'd0);
        step("blast_c", 1, 1, 0, 0, 1, 90, 90);
        step("rst_blast", 0, 1, 0, 0, 1, 100, 100);
        check("rst idle", 32'(explode), 32'd0);

        for (int k = 0; k < 400; k++) begin
            step("rand", $urandom_range(0, 59) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 39) == 0, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 2047)),
                 int'($urandom_range(0, 2047)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
